// File: rtl/iram_prog_loader_pkg.sv
// Shared types and helpers for the run-time loadable instruction memory.
// States, default-build sizes and byte-address to word-index arithmetic.
package iram_pkg;

    typedef enum logic [1:0] {
        CLEAR   = 2'd0,
        IDLE    = 2'd1,
        LOAD    = 2'd2,
        DONE_ST = 2'd3
    } state_t;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_DEPTH  = 512;
    localparam int BPW        = DEF_DATA_W / 8;
    localparam int IDX_W      = $clog2(DEF_DEPTH);
    localparam int BSEL_W     = (BPW > 1) ? $clog2(BPW) : 0;

    function automatic int byte_shift(input int data_w);
        return (data_w / 8 > 1) ? $clog2(data_w / 8) : 0;
    endfunction

    function automatic logic [31:0] word_index(input logic [31:0] addr, input int shift);
        return addr >> shift;
    endfunction

endpackage

// File: rtl/iram_prog_loader_if.sv
// Fetch port plus byte-stream load port of the instruction memory.
// master = CPU/host side, slave = the memory/loader.
interface iram_prog_loader_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 10
);
    logic [ADDR_W-1:0] ADDR;
    logic [DATA_W-1:0] Q;
    logic              MISALIGN;
    logic              LD_START;
    logic [LEN_W-1:0]  LD_LEN;
    logic              LD_VALID;
    logic [7:0]        LD_BYTE;
    logic              LD_READY;
    logic              BUSY;
    logic              DONE;
    logic              ERR;
    logic [7:0]        CKSUM;

    modport master (
        output ADDR, LD_START, LD_LEN, LD_VALID, LD_BYTE,
        input  Q, MISALIGN, LD_READY, BUSY, DONE, ERR, CKSUM
    );

    modport slave (
        input  ADDR, LD_START, LD_LEN, LD_VALID, LD_BYTE,
        output Q, MISALIGN, LD_READY, BUSY, DONE, ERR, CKSUM
    );
endinterface

// File: rtl/iram_byte_packer.sv
// Collects big-endian bytes into an instruction word; word_valid marks the
// cycle the last byte of a word arrives, with the full word on 'word'.
module iram_byte_packer #(
    parameter int DATA_W = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              clear,
    input  logic              accept,
    input  logic [7:0]        byte_in,
    output logic [DATA_W-1:0] word,
    output logic              word_valid
);
    localparam int WORD_BYTES = DATA_W / 8;
    localparam int CNT_W      = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

    logic [CNT_W-1:0] bcnt;

    assign word_valid = accept && (bcnt == CNT_W'(WORD_BYTES - 1));

    always_ff @(posedge CLK) begin
        if (RESET || clear)
            bcnt <= '0;
        else if (accept)
            bcnt <= word_valid ? '0 : bcnt + CNT_W'(1);
    end

    // Earlier bytes sit above the incoming one, so the first byte lands on top.
    if (WORD_BYTES > 1) begin : g_multi
        logic [DATA_W-9:0] partial;
        assign word = {partial, byte_in};
        always_ff @(posedge CLK) begin
            if (accept)
                partial <= word[DATA_W-9:0];
        end
    end else begin : g_single
        assign word = byte_in;
    end
endmodule

// File: rtl/iram_prog_loader.sv
// Instruction memory filled at run time from a byte stream: clears itself
// after reset, then loads words on request and reports DONE/ERR/CKSUM.
module iram_prog_loader
    import iram_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int DEPTH    = 512,
    parameter int ADDR_W   = 10,
    parameter int REG_READ = 0
) (
    input  logic              CLK,
    input  logic              RESET,
    iram_prog_loader_if.slave bus
);
    localparam int WORD_BYTES = DATA_W / 8;
    localparam int SHIFT      = byte_shift(DATA_W);
    localparam int PTR_W      = $clog2(DEPTH);
    localparam int LEN_W      = PTR_W + 1;

    state_t            state, state_next;
    logic [PTR_W-1:0]  ptr;
    logic [LEN_W-1:0]  count;
    logic [7:0]        cksum;
    logic              err;
    logic              busy, ready, done;
    logic              accept, word_valid, packer_clear, last_word, we;
    logic [DATA_W-1:0] word, wdata, fetch_word;
    logic [31:0]       fetch_idx;
    logic [DATA_W-1:0] mem [DEPTH];

    assign accept    = bus.LD_VALID && ready;
    assign last_word = (LEN_W'(ptr) + LEN_W'(1)) == count;

    iram_byte_packer #(.DATA_W(DATA_W)) u_packer (
        .CLK        (CLK),
        .RESET      (RESET),
        .clear      (packer_clear),
        .accept     (accept),
        .byte_in    (bus.LD_BYTE),
        .word       (word),
        .word_valid (word_valid)
    );

    always_ff @(posedge CLK) begin
        if (RESET)
            state <= CLEAR;
        else
            state <= state_next;
    end

    always_comb begin
        state_next   = state;
        busy         = 1'b0;
        ready        = 1'b0;
        done         = 1'b0;
        we           = 1'b0;
        wdata        = word;
        packer_clear = 1'b1;
        case (state)
            CLEAR: begin
                busy  = 1'b1;
                we    = 1'b1;
                wdata = '0;
                if (ptr == PTR_W'(DEPTH - 1))
                    state_next = IDLE;
            end
            IDLE: begin
                if (bus.LD_START) begin
                    if (bus.LD_LEN == '0)
                        state_next = DONE_ST;
                    else if (bus.LD_LEN <= LEN_W'(DEPTH))
                        state_next = LOAD;
                end
            end
            LOAD: begin
                busy         = 1'b1;
                ready        = 1'b1;
                packer_clear = 1'b0;
                we           = word_valid;
                if (word_valid && last_word)
                    state_next = DONE_ST;
            end
            DONE_ST: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = CLEAR;
        endcase
    end

    // A rejected start (too long) only raises ERR; everything else restarts the load context.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ptr   <= '0;
            count <= '0;
            cksum <= '0;
            err   <= 1'b0;
        end else begin
            case (state)
                CLEAR: ptr <= ptr + PTR_W'(1);
                IDLE: begin
                    if (bus.LD_START) begin
                        if (bus.LD_LEN > LEN_W'(DEPTH)) begin
                            err <= 1'b1;
                        end else begin
                            err   <= 1'b0;
                            cksum <= '0;
                            ptr   <= '0;
                            count <= bus.LD_LEN;
                        end
                    end
                end
                LOAD: begin
                    if (accept)
                        cksum <= cksum + bus.LD_BYTE;
                    if (word_valid)
                        ptr <= ptr + PTR_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (we)
            mem[ptr] <= wdata;
    end

    assign fetch_idx  = word_index(32'(bus.ADDR), SHIFT);
    assign fetch_word = (!busy && fetch_idx < 32'(DEPTH)) ? mem[fetch_idx[PTR_W-1:0]] : '0;

    if (REG_READ != 0) begin : g_reg_q
        logic [DATA_W-1:0] q_reg;
        always_ff @(posedge CLK) begin
            if (RESET)
                q_reg <= '0;
            else
                q_reg <= fetch_word;
        end
        assign bus.Q = q_reg;
    end else begin : g_comb_q
        assign bus.Q = fetch_word;
    end

    if (WORD_BYTES > 1) begin : g_align
        assign bus.MISALIGN = |bus.ADDR[SHIFT-1:0];
    end else begin : g_no_align
        assign bus.MISALIGN = 1'b0;
    end

    assign bus.LD_READY = ready;
    assign bus.BUSY     = busy;
    assign bus.DONE     = done;
    assign bus.ERR      = err;
    assign bus.CKSUM    = cksum;
endmodule

// File: tb/tb_iram_prog_loader.sv
// Directed bench for iram_prog_loader: a 16-bit combinational-fetch instance
// and a 32-bit registered-fetch instance, checked against a scoreboard.
module tb_iram_prog_loader;

    typedef struct {
        int          idx;
        logic [31:0] data;
    } exp_t;

    logic CLK = 1'b0;
    logic RESET;

    always #5 CLK = ~CLK;

    iram_prog_loader_if #(.DATA_W(16), .ADDR_W(10), .LEN_W(10)) bus0 ();
    iram_prog_loader_if #(.DATA_W(32), .ADDR_W(7),  .LEN_W(5))  bus1 ();

    iram_prog_loader #(.DATA_W(16), .DEPTH(512), .ADDR_W(10), .REG_READ(0)) dut0 (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus0)
    );

    iram_prog_loader #(.DATA_W(32), .DEPTH(16), .ADDR_W(7), .REG_READ(1)) dut1 (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus1)
    );

    int          checks   = 0;
    int          failures = 0;
    exp_t        sb0[$];
    exp_t        sb1[$];
    logic [15:0] mdl0 [512];
    logic [31:0] mdl1 [16];
    logic [7:0]  ck_model;
    logic [7:0]  stim[$];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge CLK);
        #1;
    endtask

    // Load on the 16-bit instance; gappy mode idles LD_VALID between bytes and pokes LD_START.
    task automatic applyStimulus0(input int len, input logic [7:0] bytes[$], input bit gappy);
        logic [15:0] w;
        int          n;
        bit          rdy_ok;
        w = '0; n = 0; rdy_ok = 1'b1; ck_model = '0;
        cycle();
        bus0.LD_START = 1'b1; bus0.LD_LEN = 10'(len); bus0.ADDR = '0;
        cycle();
        bus0.LD_START = 1'b0;
        @(negedge CLK);
        checkOutput("busy_in_load", 32'(bus0.BUSY), 32'd1);
        checkOutput("q_blocked_in_load", 32'(bus0.Q), 32'd0);
        foreach (bytes[i]) begin
            if (gappy) begin
                cycle();
                bus0.LD_VALID = 1'b0; bus0.LD_START = 1'b1; bus0.LD_LEN = 10'd1;
                @(negedge CLK);
                if (bus0.LD_READY !== 1'b1) rdy_ok = 1'b0;
            end
            cycle();
            bus0.LD_START = 1'b0; bus0.LD_VALID = 1'b1; bus0.LD_BYTE = bytes[i];
            @(negedge CLK);
            if (bus0.LD_READY !== 1'b1) rdy_ok = 1'b0;
            ck_model += bytes[i];
            w = {w[7:0], bytes[i]};
            n++;
            if (n % 2 == 0) begin
                mdl0[n/2-1] = w;
                sb0.push_back('{idx: n/2-1, data: 32'(w)});
            end
        end
        cycle();
        bus0.LD_VALID = 1'b0;
        @(negedge CLK);
        checkOutput("ready_in_load", 32'(rdy_ok), 32'd1);
        checkOutput("done_pulse", 32'(bus0.DONE), 32'd1);
        checkOutput("busy_at_done", 32'(bus0.BUSY), 32'd0);
        cycle();
        @(negedge CLK);
        checkOutput("done_single", 32'(bus0.DONE), 32'd0);
        checkOutput("cksum0", 32'(bus0.CKSUM), 32'(ck_model));
    endtask

    task automatic applyStimulus1(input int len, input logic [7:0] bytes[$]);
        logic [31:0] w;
        int          n;
        w = '0; n = 0; ck_model = '0;
        cycle();
        bus1.LD_START = 1'b1; bus1.LD_LEN = 5'(len);
        cycle();
        bus1.LD_START = 1'b0;
        foreach (bytes[i]) begin
            cycle();
            bus1.LD_VALID = 1'b1; bus1.LD_BYTE = bytes[i];
            ck_model += bytes[i];
            w = {w[23:0], bytes[i]};
            n++;
            if (n % 4 == 0) begin
                mdl1[n/4-1] = w;
                sb1.push_back('{idx: n/4-1, data: w});
            end
        end
        cycle();
        bus1.LD_VALID = 1'b0;
        @(negedge CLK);
        checkOutput("done1_pulse", 32'(bus1.DONE), 32'd1);
        checkOutput("cksum1", 32'(bus1.CKSUM), 32'(ck_model));
    endtask

    task automatic verifyWords0(input string tag);
        exp_t e;
        while (sb0.size() > 0) begin
            e = sb0.pop_front();
            cycle();
            bus0.ADDR = 10'(e.idx * 2);
            @(negedge CLK);
            checkOutput(tag, 32'(bus0.Q), e.data);
        end
    endtask

    task automatic waitClear();
        repeat (511) @(posedge CLK);
        @(negedge CLK);
        checkOutput("busy_last_clear", 32'(bus0.BUSY), 32'd1);
        @(posedge CLK);
        @(negedge CLK);
        checkOutput("busy_falls", 32'(bus0.BUSY), 32'd0);
    endtask

    initial begin
        RESET = 1'b1;
        bus0.ADDR = '0; bus0.LD_START = 1'b0; bus0.LD_LEN = '0; bus0.LD_VALID = 1'b0; bus0.LD_BYTE = '0;
        bus1.ADDR = '0; bus1.LD_START = 1'b0; bus1.LD_LEN = '0; bus1.LD_VALID = 1'b0; bus1.LD_BYTE = '0;
        for (int i = 0; i < 512; i++) mdl0[i] = '0;
        for (int i = 0; i < 16; i++) mdl1[i] = '0;

        repeat (3) @(posedge CLK);
        #1;
        RESET = 1'b0;
        @(negedge CLK);
        checkOutput("rst_busy", 32'(bus0.BUSY), 32'd1);
        checkOutput("rst_ready", 32'(bus0.LD_READY), 32'd0);
        checkOutput("rst_done", 32'(bus0.DONE), 32'd0);
        checkOutput("rst_err", 32'(bus0.ERR), 32'd0);
        checkOutput("rst_cksum", 32'(bus0.CKSUM), 32'd0);
        checkOutput("rst_q", 32'(bus0.Q), 32'd0);
        waitClear();
        checkOutput("dut1_idle", 32'(bus1.BUSY), 32'd0);

        foreach (sb0[i]) ;
        sb0.push_back('{idx: 0, data: 32'd0});
        sb0.push_back('{idx: 1, data: 32'd0});
        sb0.push_back('{idx: 511, data: 32'd0});
        verifyWords0("q_after_clear");
        cycle(); bus0.ADDR = 10'd3;
        @(negedge CLK);
        checkOutput("misalign_3", 32'(bus0.MISALIGN), 32'd1);
        cycle(); bus0.ADDR = 10'd2;
        @(negedge CLK);
        checkOutput("misalign_2", 32'(bus0.MISALIGN), 32'd0);

        stim = '{8'hF0, 8'h01, 8'hF2, 8'h11, 8'h5F, 8'hFF};
        applyStimulus0(3, stim, 1'b0);
        verifyWords0("load_word");
        applyStimulus0(3, stim, 1'b1);
        verifyWords0("gappy_word");

        cycle(); bus0.LD_START = 1'b1; bus0.LD_LEN = 10'd513;
        cycle(); bus0.LD_START = 1'b0; bus0.ADDR = 10'd4;
        @(negedge CLK);
        checkOutput("err_set", 32'(bus0.ERR), 32'd1);
        checkOutput("err_no_busy", 32'(bus0.BUSY), 32'd0);
        checkOutput("err_mem_kept", 32'(bus0.Q), 32'(mdl0[2]));

        cycle(); bus0.LD_START = 1'b1; bus0.LD_LEN = 10'd0;
        cycle(); bus0.LD_START = 1'b0;
        @(negedge CLK);
        checkOutput("len0_done", 32'(bus0.DONE), 32'd1);
        checkOutput("len0_err_clr", 32'(bus0.ERR), 32'd0);
        checkOutput("len0_cksum", 32'(bus0.CKSUM), 32'd0);
        cycle();
        @(negedge CLK);
        checkOutput("len0_done_single", 32'(bus0.DONE), 32'd0);
        checkOutput("len0_mem_kept", 32'(bus0.Q), 32'(mdl0[2]));

        stim = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        applyStimulus1(2, stim);
        while (sb1.size() > 0) begin
            exp_t e;
            e = sb1.pop_front();
            cycle(); bus1.ADDR = 7'(e.idx * 4);
            cycle();
            @(negedge CLK);
            checkOutput("reg_word", bus1.Q, e.data);
        end
        cycle(); bus1.ADDR = 7'd0;
        @(negedge CLK);
        checkOutput("reg_hold_0", bus1.Q, mdl1[1]);
        cycle();
        @(negedge CLK);
        checkOutput("reg_update_0", bus1.Q, mdl1[0]);
        cycle(); bus1.ADDR = 7'd4;
        @(negedge CLK);
        checkOutput("reg_hold_4", bus1.Q, mdl1[0]);
        cycle();
        @(negedge CLK);
        checkOutput("reg_update_4", bus1.Q, mdl1[1]);
        cycle(); bus1.ADDR = 7'd2;
        @(negedge CLK);
        checkOutput("misalign1_2", 32'(bus1.MISALIGN), 32'd1);
        cycle(); bus1.ADDR = 7'd64;
        @(negedge CLK);
        checkOutput("misalign1_64", 32'(bus1.MISALIGN), 32'd0);
        cycle();
        @(negedge CLK);
        checkOutput("reg_out_of_range", bus1.Q, 32'd0);

        cycle(); bus0.LD_START = 1'b1; bus0.LD_LEN = 10'd4;
        cycle(); bus0.LD_START = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle(); bus0.LD_VALID = 1'b1; bus0.LD_BYTE = 8'hA0 + 8'(i);
        end
        cycle(); bus0.LD_VALID = 1'b0; RESET = 1'b1;
        cycle(); RESET = 1'b0;
        @(negedge CLK);
        checkOutput("midrst_busy", 32'(bus0.BUSY), 32'd1);
        checkOutput("midrst_cksum", 32'(bus0.CKSUM), 32'd0);
        checkOutput("midrst_ready", 32'(bus0.LD_READY), 32'd0);
        waitClear();
        for (int i = 0; i < 512; i++) mdl0[i] = '0;
        for (int i = 0; i < 4; i++) sb0.push_back('{idx: i, data: 32'(mdl0[i])});
        verifyWords0("midrst_cleared");
        checkOutput("midrst_cksum_end", 32'(bus0.CKSUM), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
